// File: rtl/dft_mac_if.sv
// Stream/memory bundle of the DFT MAC engine: control, sample and twiddle
// fetch ports, and the result stream.
interface dft_mac_if #(
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 12,
  parameter int LANES      = 2
);
  logic                           start;
  logic                           abort;
  logic                           inverse;
  logic [AW-1:0]                  samp_number;
  logic                           rd_en;
  logic [AW-1:0]                  rd_addr;
  logic signed [DATA_WIDTH-1:0]   rd_data;
  logic [LANES*AW-1:0]            tw_addr;
  logic [LANES*DATA_WIDTH-1:0]    tw_re;
  logic [LANES*DATA_WIDTH-1:0]    tw_im;
  logic                           res_valid;
  logic                           res_ready;
  logic [AW-1:0]                  res_k;
  logic signed [DATA_WIDTH-1:0]   res_re;
  logic signed [DATA_WIDTH-1:0]   res_im;
  logic                           busy;
  logic                           done;
  logic                           err;

  modport slave (
    input  start, abort, inverse, samp_number, rd_data, tw_re, tw_im, res_ready,
    output rd_en, rd_addr, tw_addr, res_valid, res_k, res_re, res_im, busy, done, err
  );

  modport master (
    output start, abort, inverse, samp_number, rd_data, tw_re, tw_im, res_ready,
    input  rd_en, rd_addr, tw_addr, res_valid, res_k, res_re, res_im, busy, done, err
  );
endinterface

// File: rtl/dft_mac_engine.sv
// Multi-lane direct DFT: LANES bins per pass over N real samples, twiddle phase
// tracked by modular addition, results rounded/saturated onto a valid/ready stream.
module dft_mac_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_N      = 4096,
  parameter int AW         = 12,
  parameter int LANES      = 2
) (
  input  logic     clk,
  input  logic     rst,
  dft_mac_if.slave bus
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int KW = AW + 2;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [AW:0] MAX_N_W = (AW+1)'(MAX_N);
  localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'((2 ** (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH+1)'(-(2 ** (DATA_WIDTH-1)));
  localparam logic signed [ACC_WIDTH:0] HALF   = (ACC_WIDTH+1)'(2 ** (DATA_WIDTH-2));

  typedef enum logic [2:0] {IDLE = 3'd0, ACC = 3'd1, DRAIN = 3'd2, OUT = 3'd3, NEXT = 3'd4} state_t;

  state_t                        state_r, state_nx;
  logic [AW-1:0]                 n_r, cnt_r, kb_r;
  logic                          inv_r;
  logic [LW-1:0]                 lane_r;
  logic [AW-1:0]                 phase_r  [LANES];
  logic [AW-1:0]                 phase_nx_s [LANES];
  logic [KW-1:0]                 psum_s   [LANES];
  logic                          va_r, vb_r, vc_r;
  logic signed [DATA_WIDTH-1:0]  x_r;
  logic signed [DATA_WIDTH-1:0]  cos_r [LANES];
  logic signed [DATA_WIDTH-1:0]  sin_r [LANES];
  logic signed [PW-1:0]          pre_r [LANES];
  logic signed [PW-1:0]          pim_r [LANES];
  logic signed [ACC_WIDTH-1:0]   acc_re_r [LANES];
  logic signed [ACC_WIDTH-1:0]   acc_im_r [LANES];
  logic                          done_r, err_r;

  logic          start_ok_s, acc_last_s, drain_last_s, more_s, last_pass_s;
  logic [KW-1:0] kb_ext_s, n_ext_s, cur_k_s, nxt_k_s;

  // Round half up, then clamp into the output sample range.
  function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH:0] v;
    v = ((ACC_WIDTH+1)'(a) + HALF) >>> (DATA_WIDTH-1);
    if (v > SAT_HI) begin
      return SAT_HI[DATA_WIDTH-1:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[DATA_WIDTH-1:0];
    end else begin
      return v[DATA_WIDTH-1:0];
    end
  endfunction

  assign start_ok_s   = (bus.samp_number != '0) && ({1'b0, bus.samp_number} <= MAX_N_W);
  assign kb_ext_s     = {2'b00, kb_r};
  assign n_ext_s      = {2'b00, n_r};
  assign cur_k_s      = kb_ext_s + KW'(lane_r);
  assign nxt_k_s      = cur_k_s + KW'(1);
  assign more_s       = (lane_r != LW'(LANES-1)) && (nxt_k_s < n_ext_s);
  assign last_pass_s  = (kb_ext_s + KW'(LANES)) >= n_ext_s;
  assign acc_last_s   = (cnt_r == n_r - AW'(1));
  assign drain_last_s = (cnt_r == AW'(2));

  // Next phase per lane: p + k reduced once modulo N.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      psum_s[i] = {2'b00, phase_r[i]} + kb_ext_s + KW'(i);
      if (psum_s[i] >= n_ext_s) begin
        phase_nx_s[i] = AW'(psum_s[i] - n_ext_s);
      end else begin
        phase_nx_s[i] = AW'(psum_s[i]);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nx = state_r;
    if (bus.abort) begin
      state_nx = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (bus.start && start_ok_s) state_nx = ACC;   else state_nx = IDLE;
        ACC:     if (acc_last_s)              state_nx = DRAIN; else state_nx = ACC;
        DRAIN:   if (drain_last_s)            state_nx = OUT;   else state_nx = DRAIN;
        OUT:     if (bus.res_ready && !more_s) state_nx = NEXT; else state_nx = OUT;
        NEXT:    if (last_pass_s)             state_nx = IDLE;  else state_nx = ACC;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Control registers: counters, latched job parameters, phases, pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r <= '0; cnt_r <= '0; kb_r <= '0; inv_r <= 1'b0; lane_r <= '0;
      done_r <= 1'b0; err_r <= 1'b0;
      for (int i = 0; i < LANES; i++) phase_r[i] <= '0;
    end else if (bus.abort) begin
      n_r <= '0; cnt_r <= '0; kb_r <= '0; inv_r <= 1'b0; lane_r <= '0;
      done_r <= 1'b0; err_r <= 1'b0;
      for (int i = 0; i < LANES; i++) phase_r[i] <= '0;
    end else begin
      done_r <= (state_r == NEXT) && last_pass_s;
      err_r  <= (state_r == IDLE) && bus.start && !start_ok_s;
      if (state_r == IDLE && bus.start && start_ok_s) begin
        n_r <= bus.samp_number; inv_r <= bus.inverse; kb_r <= '0;
      end
      if (state_r == ACC) begin
        cnt_r <= acc_last_s ? '0 : cnt_r + AW'(1);
      end else if (state_r == DRAIN) begin
        cnt_r <= drain_last_s ? '0 : cnt_r + AW'(1);
      end else begin
        cnt_r <= '0;
      end
      if (state_r == OUT) begin
        if (bus.res_ready && more_s) lane_r <= lane_r + LW'(1);
      end else begin
        lane_r <= '0;
      end
      if (state_r == NEXT) begin
        kb_r <= last_pass_s ? '0 : kb_r + AW'(LANES);
      end
      for (int i = 0; i < LANES; i++) begin
        if (state_r == ACC) phase_r[i] <= phase_nx_s[i];
        else if (state_r == NEXT) phase_r[i] <= '0;
      end
    end
  end

  // Fetch -> multiply -> accumulate pipeline; valid tags follow rd_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va_r <= 1'b0; vb_r <= 1'b0; vc_r <= 1'b0; x_r <= '0;
      for (int i = 0; i < LANES; i++) begin
        cos_r[i] <= '0; sin_r[i] <= '0; pre_r[i] <= '0; pim_r[i] <= '0;
        acc_re_r[i] <= '0; acc_im_r[i] <= '0;
      end
    end else if (bus.abort) begin
      va_r <= 1'b0; vb_r <= 1'b0; vc_r <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc_re_r[i] <= '0; acc_im_r[i] <= '0;
      end
    end else begin
      va_r <= (state_r == ACC);
      vb_r <= va_r;
      vc_r <= vb_r;
      x_r  <= bus.rd_data;
      for (int i = 0; i < LANES; i++) begin
        cos_r[i] <= bus.tw_re[i*DATA_WIDTH +: DATA_WIDTH];
        sin_r[i] <= bus.tw_im[i*DATA_WIDTH +: DATA_WIDTH];
        pre_r[i] <= x_r * cos_r[i];
        pim_r[i] <= x_r * sin_r[i];
        if (state_r == NEXT) begin
          acc_re_r[i] <= '0;
          acc_im_r[i] <= '0;
        end else if (vc_r) begin
          acc_re_r[i] <= acc_re_r[i] + ACC_WIDTH'(pre_r[i]);
          acc_im_r[i] <= inv_r ? acc_im_r[i] + ACC_WIDTH'(pim_r[i])
                               : acc_im_r[i] - ACC_WIDTH'(pim_r[i]);
        end
      end
    end
  end

  // Output decode; everything outside its active state reads as zero.
  always_comb begin
    bus.rd_en     = (state_r == ACC);
    bus.rd_addr   = (state_r == ACC) ? cnt_r : '0;
    bus.tw_addr   = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.tw_addr[i*AW +: AW] = (state_r == ACC) ? phase_r[i] : '0;
    end
    bus.res_valid = (state_r == OUT);
    if (state_r == OUT) begin
      bus.res_k  = AW'(cur_k_s);
      bus.res_re = round_sat(acc_re_r[lane_r]);
      bus.res_im = round_sat(acc_im_r[lane_r]);
    end else begin
      bus.res_k  = '0;
      bus.res_re = '0;
      bus.res_im = '0;
    end
    bus.busy = (state_r != IDLE);
    bus.done = done_r;
    bus.err  = err_r;
  end
endmodule

// File: tb/tb_dft_mac_engine.sv
// Self-checking bench: sample RAM and twiddle ROM models, DFT reference computed
// directly from sum x[n]*W^(k*n mod N), plus control-path scenarios.
module tb_dft_mac_engine;
  localparam int DW = 16, ACCW = 40, MAXN = 32, AW = 6, LANES = 2;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dft_mac_if #(.DATA_WIDTH(DW), .AW(AW), .LANES(LANES)) bus ();

  dft_mac_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(ACCW), .MAX_N(MAXN), .AW(AW), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int checks = 0, failures = 0;
  logic signed [DW-1:0] mem [MAXN];
  int cos_t [MAXN], sin_t [MAXN];
  int exp_re [MAXN], exp_im [MAXN];
  int cur_n = 1;
  int got_k [$], got_re [$], got_im [$];
  int done_cnt, done_busy_bad, busy_cycles, unstable;

  // External memories: one-cycle read latency.
  always @(posedge clk) begin
    bus.rd_data <= mem[bus.rd_addr % MAXN];
    for (int i = 0; i < LANES; i++) begin
      bus.tw_re[i*DW +: DW] <= DW'(cos_t[int'(bus.tw_addr[i*AW +: AW]) % cur_n]);
      bus.tw_im[i*DW +: DW] <= DW'(sin_t[int'(bus.tw_addr[i*AW +: AW]) % cur_n]);
    end
  end

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
  endfunction

  function automatic void set_tables(input int n);
    for (int m = 0; m < n; m++) begin
      cos_t[m] = rnd(32767.0 * $cos(2.0 * PI * m / n));
      sin_t[m] = rnd(32767.0 * $sin(2.0 * PI * m / n));
    end
  endfunction

  function automatic int round_sat(input longint a);
    longint v;
    v = (a + (longint'(1) <<< (DW-2))) >>> (DW-1);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  task automatic test_transform(input string name, input int n, input bit inv, input int mode, input int inject);
    longint sr, si;
    int hold, exp_busy;
    bit finished;
    logic [AW+2*DW-1:0] prev;
    cur_n = n;
    set_tables(n);
    for (int k = 0; k < n; k++) begin
      sr = 0; si = 0;
      for (int t = 0; t < n; t++) begin
        sr += longint'(mem[t]) * longint'(cos_t[(k*t) % n]);
        si += (inv ? 1 : -1) * longint'(mem[t]) * longint'(sin_t[(k*t) % n]);
      end
      exp_re[k] = round_sat(sr);
      exp_im[k] = round_sat(si);
    end
    got_k.delete(); got_re.delete(); got_im.delete();
    done_cnt = 0; done_busy_bad = 0; busy_cycles = 0; unstable = 0; hold = 0;
    finished = 1'b0; prev = '0;
    @(negedge clk);
    bus.samp_number = AW'(n); bus.inverse = inv; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.samp_number = AW'($urandom); bus.inverse = ~inv;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_cnt++;
        if (bus.busy) done_busy_bad++;
      end
      if (cyc == inject) begin
        bus.samp_number = AW'(n % 7 + 1); bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (mode == 0) begin
        bus.res_ready = 1'b1;
      end else if (mode == 2) begin
        bus.res_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.res_ready = 1'b0;
        if (bus.res_valid) begin
          if (hold > 0 && {bus.res_k, bus.res_re, bus.res_im} !== prev) unstable++;
          prev = {bus.res_k, bus.res_re, bus.res_im};
          if (hold == 5) begin
            bus.res_ready = 1'b1; hold = 0;
          end else begin
            hold++;
          end
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        got_k.push_back(int'(bus.res_k));
        got_re.push_back(int'(bus.res_re));
        got_im.push_back(int'(bus.res_im));
      end
      if (bus.done && !bus.busy) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.res_ready = 1'b0;
    checks++;
    if (!finished) begin failures++; $display("FAIL %s timeout: done not seen within budget", name); end
    checks++;
    if (got_k.size() != n) begin failures++; $display("FAIL %s count: got %0d results, expected %0d", name, got_k.size(), n); end
    for (int i = 0; i < got_k.size() && i < n; i++) begin
      checks++;
      if (got_k[i] != i) begin failures++; $display("FAIL %s k[%0d]: got %0d expected %0d", name, i, got_k[i], i); end
      checks++;
      if (got_re[i] != exp_re[i]) begin failures++; $display("FAIL %s re k=%0d: got %0d expected %0d", name, i, got_re[i], exp_re[i]); end
      checks++;
      if (got_im[i] != exp_im[i]) begin failures++; $display("FAIL %s im k=%0d: got %0d expected %0d", name, i, got_im[i], exp_im[i]); end
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL %s done pulses: got %0d expected 1", name, done_cnt); end
    checks++;
    if (done_busy_bad != 0) begin failures++; $display("FAIL %s busy with done: got %0d expected 0", name, done_busy_bad); end
    if (mode == 0) begin
      exp_busy = ((n + LANES - 1) / LANES) * (n + 4) + n;
      checks++;
      if (busy_cycles != exp_busy) begin failures++; $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cycles, exp_busy); end
    end
    if (mode == 1) begin
      checks++;
      if (unstable != 0) begin failures++; $display("FAIL %s stall stability: got %0d changes expected 0", name, unstable); end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.rd_en, bus.res_valid, bus.busy, bus.done, bus.err} !== 5'b0) begin
      failures++; $display("FAIL reset flags: got %b expected 00000", {bus.rd_en, bus.res_valid, bus.busy, bus.done, bus.err});
    end
    checks++;
    if ({bus.rd_addr, bus.tw_addr, bus.res_k, bus.res_re, bus.res_im} !== '0) begin
      failures++; $display("FAIL reset buses: got %h expected 0", {bus.rd_addr, bus.tw_addr, bus.res_k, bus.res_re, bus.res_im});
    end
  endtask

  task automatic test_impulse();
    mem[0] = 16'sh4000; mem[1] = '0; mem[2] = '0; mem[3] = '0;
    test_transform("impulse", 4, 1'b0, 0, -1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) mem[i] = 16'sh2000;
    test_transform("sat_pos", 4, 1'b0, 0, -1);
    for (int i = 0; i < 8; i++) mem[i] = -16'sh7FFF - 16'sh0001;
    test_transform("sat_neg", 8, 1'b0, 0, -1);
  endtask

  task automatic test_cosine_inverse();
    for (int i = 0; i < 8; i++) mem[i] = DW'(rnd(4096.0 * $cos(2.0 * PI * i / 8)));
    test_transform("cos_fwd", 8, 1'b0, 0, -1);
    for (int i = 0; i < 8; i++) mem[i] = DW'(rnd(4096.0 * $sin(2.0 * PI * i / 8)));
    test_transform("sin_fwd", 8, 1'b0, 0, -1);
    test_transform("sin_inv", 8, 1'b1, 0, -1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) mem[i] = DW'($urandom_range(0, 8000) - 4000);
    test_transform("backpressure", 3, 1'b0, 1, -1);
  endtask

  task automatic test_errors();
    int bad_n [2];
    bad_n[0] = 0; bad_n[1] = MAXN + 1;
    foreach (bad_n[j]) begin
      @(negedge clk);
      bus.samp_number = AW'(bad_n[j]); bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL err_pulse N=%0d: got err=%b busy=%b expected err=1 busy=0", bad_n[j], bus.err, bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL err_clear N=%0d: got err=%b busy=%b expected 0 0", bad_n[j], bus.err, bus.busy);
      end
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 5; i++) mem[i] = DW'($urandom_range(0, 20000) - 10000);
    test_transform("start_in_acc", 5, 1'b1, 0, 2);
  endtask

  task automatic test_abort();
    int seen_done;
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom_range(0, 4000) - 2000);
    @(negedge clk);
    bus.samp_number = AW'(16); bus.inverse = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if ({bus.busy, bus.rd_en, bus.res_valid, bus.done} !== 4'b0 || {bus.rd_addr, bus.tw_addr} !== '0) begin
      failures++; $display("FAIL abort_idle: got busy=%b rd_en=%b addr=%h expected all 0", bus.busy, bus.rd_en, {bus.rd_addr, bus.tw_addr});
    end
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin failures++; $display("FAIL abort_quiet: got %0d active cycles expected 0", seen_done); end
    test_transform("abort_rerun", 16, 1'b0, 0, -1);
  endtask

  task automatic test_random();
    int n, amp;
    for (int r = 0; r < 7; r++) begin
      n = (r == 0) ? 1 : (r == 1) ? MAXN : $urandom_range(1, MAXN);
      amp = ($urandom_range(0, 1) == 1) ? 32767 : 2047;
      for (int i = 0; i < n; i++) mem[i] = DW'($urandom_range(0, 2 * amp) - amp);
      test_transform($sformatf("random%0d_n%0d", r, n), n, 1'($urandom_range(0, 1)), (r < 2) ? 0 : 2, -1);
    end
  endtask

  task automatic test_reset_in_out();
    bit found;
    mem[0] = 16'sh4000; mem[1] = '0; mem[2] = '0; mem[3] = '0;
    cur_n = 4; set_tables(4);
    found = 1'b0;
    @(negedge clk);
    bus.res_ready = 1'b0; bus.samp_number = AW'(4); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.res_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found || bus.res_re !== 16'sh4000) begin
      failures++; $display("FAIL rst_out_reach: found=%b re=%h expected valid with 4000", found, bus.res_re);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.res_valid, bus.busy, bus.rd_en, bus.done, bus.err} !== 5'b0 || {bus.res_k, bus.res_re, bus.res_im} !== '0) begin
      failures++; $display("FAIL rst_async: got valid=%b busy=%b re=%h expected all 0", bus.res_valid, bus.busy, bus.res_re);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.inverse = 1'b0;
    bus.samp_number = '0; bus.res_ready = 1'b0;
    for (int i = 0; i < MAXN; i++) begin
      mem[i] = '0; cos_t[i] = 0; sin_t[i] = 0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_impulse();
    test_saturation();
    test_cosine_inverse();
    test_backpressure();
    test_errors();
    test_start_ignored();
    test_abort();
    test_random();
    test_reset_in_out();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
